// File: rtl/simple_cpu_pkg.sv
// Shared constants and types for the simple_cpu instruction fetch stage.
//
// Contents:
//   INSTR_WIDTH   - instruction word width (matches simple_cpu)
//   PC_BITS       - program counter / program memory address width
//   HALT_WORD     - fetched word that stops fetch; never issued to the CPU
//   fetch_state_t - fetch FSM states
//   OP_ALU/OP_LOAD/OP_STORE - opcode class held in instruction bits [19:18]
//   opcode_of()   - extracts the opcode class from an instruction word
package simple_cpu_pkg;

  localparam int INSTR_WIDTH = 20;
  localparam int PC_BITS     = 5;

  localparam logic [INSTR_WIDTH-1:0] HALT_WORD = {INSTR_WIDTH{1'b1}};
  localparam logic [PC_BITS-1:0]     PC_LAST   = {PC_BITS{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_ISSUE = 3'd3,
    S_HALT  = 3'd4
  } fetch_state_t;

  localparam logic [1:0] OP_ALU   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_STORE = 2'b11;

  function automatic logic [1:0] opcode_of(input logic [INSTR_WIDTH-1:0] word);
    return word[INSTR_WIDTH-1 -: 2];
  endfunction

endpackage

// File: rtl/instr_fetch_mem.sv
// instr_mem: program memory for the fetch stage.
// 2^AW words of DW bits, synchronous write, synchronous registered read
// (rd_data shows mem[raddr] one edge after raddr is presented).
// Contents are never reset.
//
// Ports:
//   clk     - system clock, rising edge
//   wen     - write enable
//   waddr   - write address
//   wdata   - write data
//   raddr   - read address
//   rd_data - registered read data
module instr_mem #(
  parameter int AW = 5,
  parameter int DW = 20
) (
  input  logic          clk,
  input  logic          wen,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [0:(2**AW)-1];

  always_ff @(posedge clk) begin
    if (wen) begin
      mem[waddr] <= wdata;
    end
    rd_data <= mem[raddr];
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage feeding simple_cpu.
// Holds a writable program memory and a PC, walks the program from PC 0
// after start, and presents one instruction at a time until the CPU
// retires it with cpu_done. Fetching HALT_WORD stops execution.
//
// Handshake: instr_valid rises with a new instruction and both stay
// stable until the cycle cpu_done is sampled high in ISSUE; cpu_done is
// a one-cycle retire pulse and is ignored in every other state.
//
// Ports:
//   clk, rst     - clock (rising edge), async active-high reset
//   start        - begin fetching at PC 0 (honoured in IDLE/HALT only)
//   prog_wen     - program write enable (honoured in IDLE/HALT only)
//   prog_addr    - program write address
//   prog_data    - program write data
//   cpu_done     - retire pulse from the CPU
//   instruction  - registered instruction to the CPU
//   instr_valid  - instruction valid and held
//   pc           - address of the current or next fetch
//   busy         - high in FETCH, LOAD, ISSUE
//   halted       - high in HALT
//   state_dbg    - current FSM state for observation
//
// Build option: define PC_WRAP_EN to make retiring the last address wrap
// PC to 0 and keep fetching; otherwise it enters HALT.
module instr_fetch
  import simple_cpu_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   prog_wen,
  input  logic [PC_BITS-1:0]     prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  input  logic                   cpu_done,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic [PC_BITS-1:0]     pc,
  output logic                   busy,
  output logic                   halted,
  output fetch_state_t           state_dbg
);

  fetch_state_t           state;
  logic [INSTR_WIDTH-1:0] rd_data;
  logic                   mem_wen;

  assign busy      = (state == S_FETCH) || (state == S_LOAD) || (state == S_ISSUE);
  assign halted    = (state == S_HALT);
  assign state_dbg = state;

  // The running program cannot be modified.
  assign mem_wen = prog_wen && !busy;

  instr_mem #(
    .AW (PC_BITS),
    .DW (INSTR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wen     (mem_wen),
    .waddr   (prog_addr),
    .wdata   (prog_data),
    .raddr   (pc),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= '0;
      instruction <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state <= S_FETCH;
            pc    <= '0;
          end
        end
        // rd_data captures mem[pc] on this edge.
        S_FETCH: begin
          state <= S_LOAD;
        end
        // HALT_WORD is never issued; instruction keeps its old value.
        S_LOAD: begin
          if (rd_data == HALT_WORD) begin
            state <= S_HALT;
          end else begin
            instruction <= rd_data;
            instr_valid <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cpu_done) begin
            instr_valid <= 1'b0;
            if (pc == PC_LAST) begin
`ifdef PC_WRAP_EN
              pc    <= '0;
              state <= S_FETCH;
`else
              state <= S_HALT;
`endif
            end else begin
              pc    <= pc + PC_BITS'(1);
              state <= S_FETCH;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch: reset values, basic program with
// HALT_WORD, fetch latency and retire bubble, ignored inputs, reset during
// ISSUE with memory retention, and end-of-memory behaviour (halt, or wrap
// when built with PC_WRAP_EN).
module tb_instr_fetch;
  import simple_cpu_pkg::*;

  logic                   clk;
  logic                   rst;
  logic                   start;
  logic                   prog_wen;
  logic [PC_BITS-1:0]     prog_addr;
  logic [INSTR_WIDTH-1:0] prog_data;
  logic                   cpu_done;
  logic [INSTR_WIDTH-1:0] instruction;
  logic                   instr_valid;
  logic [PC_BITS-1:0]     pc;
  logic                   busy;
  logic                   halted;
  fetch_state_t           state_dbg;

  int n_assert;
  int n_fail;

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .prog_wen    (prog_wen),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .cpu_done    (cpu_done),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted),
    .state_dbg   (state_dbg)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [PC_BITS-1:0] a, input logic [INSTR_WIDTH-1:0] d);
    prog_wen  = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_wen  = 1'b0;
  endtask

  // Wait (bounded) until an instruction is issued or fetch halts.
  task automatic wait_issue(output int cyc);
    cyc = 0;
    while (!(instr_valid || halted) && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  // Entered the cycle after instr_valid rose; holds for 3 more cycles so
  // cpu_done is sampled on the 4th edge after the rise, then checks the
  // retire edge.
  task automatic hold_and_retire(input string tag, input logic [INSTR_WIDTH-1:0] exp_word,
                                 input int exp_next_pc);
    check({tag, "_word"}, 32'(instruction), 32'(exp_word));
    repeat (3) tick();
    check({tag, "_held"}, 32'(instruction), 32'(exp_word));
    check({tag, "_held_valid"}, 32'(instr_valid), 32'd1);
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    check({tag, "_retire_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_retire_pc"}, 32'(pc), 32'(exp_next_pc));
  endtask

  initial begin
    int cyc;
    n_assert  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    start     = 1'b0;
    prog_wen  = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    cpu_done  = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_instruction", 32'(instruction), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(S_IDLE));
    rst = 1'b0;
    tick();

    // Program words 1..3; word 0 is written together with start below.
    write_word(5'd1, 20'h53000);
    write_word(5'd2, 20'h72001);
    write_word(5'd3, HALT_WORD);

    // cpu_done in IDLE is ignored
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    check("idle_done_pc", 32'(pc), 32'd0);
    check("idle_done_state", 32'(state_dbg), 32'(S_IDLE));

    // Write addr 0 and start on the same edge (edge N)
    prog_wen  = 1'b1;
    prog_addr = 5'd0;
    prog_data = 20'h47000;
    start     = 1'b1;
    tick();
    prog_wen  = 1'b0;
    start     = 1'b0;
    check("n_state_fetch", 32'(state_dbg), 32'(S_FETCH));
    check("n_busy", 32'(busy), 32'd1);
    check("n_valid", 32'(instr_valid), 32'd0);
    // cpu_done in FETCH is ignored
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    check("n1_state_load", 32'(state_dbg), 32'(S_LOAD));
    check("n1_pc", 32'(pc), 32'd0);
    check("n1_valid", 32'(instr_valid), 32'd0);
    tick();
    check("n2_valid", 32'(instr_valid), 32'd1);
    check("n2_state_issue", 32'(state_dbg), 32'(S_ISSUE));

    // start and prog_wen while busy are ignored
    start     = 1'b1;
    prog_wen  = 1'b1;
    prog_addr = 5'd1;
    prog_data = 20'h00000;
    tick();
    start     = 1'b0;
    prog_wen  = 1'b0;
    check("busy_start_state", 32'(state_dbg), 32'(S_ISSUE));
    check("busy_start_valid", 32'(instr_valid), 32'd1);

    hold_and_retire("w0", 20'h47000, 1);
    wait_issue(cyc);
    check("w1_bubble", 32'(cyc), 32'd2);
    check("w1_opcode", 32'(opcode_of(instruction)), 32'(OP_ALU));
    hold_and_retire("w1", 20'h53000, 2);
    wait_issue(cyc);
    check("w2_bubble", 32'(cyc), 32'd2);
    hold_and_retire("w2", 20'h72001, 3);
    wait_issue(cyc);
    check("halt_cycles", 32'(cyc), 32'd2);
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_valid", 32'(instr_valid), 32'd0);
    check("halt_busy", 32'(busy), 32'd0);
    check("halt_pc", 32'(pc), 32'd3);
    check("halt_instruction", 32'(instruction), 32'h72001);

    // Restart from HALT, then reset during ISSUE
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_halted", 32'(halted), 32'd0);
    wait_issue(cyc);
    hold_and_retire("r0", 20'h47000, 1);
    wait_issue(cyc);
    check("r1_word", 32'(instruction), 32'h53000);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_instruction", 32'(instruction), 32'd0);
    check("mid_rst_valid", 32'(instr_valid), 32'd0);
    check("mid_rst_pc", 32'(pc), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_state", 32'(state_dbg), 32'(S_IDLE));
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_issue(cyc);
    hold_and_retire("p0", 20'h47000, 1);
    wait_issue(cyc);
    check("p1_word", 32'(instruction), 32'h53000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // End of memory: 32 ALU words, no HALT_WORD
    for (int i = 0; i < 32; i++) begin
      write_word(5'(i), 20'h40000 + 20'(i));
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      wait_issue(cyc);
      check($sformatf("eom_word%0d", i), 32'(instruction), 32'h40000 + 32'(i));
      check($sformatf("eom_pc%0d", i), 32'(pc), 32'(i));
      cpu_done = 1'b1;
      tick();
      cpu_done = 1'b0;
    end
    wait_issue(cyc);
`ifdef PC_WRAP_EN
    check("wrap_valid", 32'(instr_valid), 32'd1);
    check("wrap_word", 32'(instruction), 32'h40000);
    check("wrap_pc", 32'(pc), 32'd0);
    check("wrap_halted", 32'(halted), 32'd0);
`else
    check("eom_halted", 32'(halted), 32'd1);
    check("eom_valid", 32'(instr_valid), 32'd0);
    check("eom_pc", 32'(pc), 32'd31);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
